rx_packet_sequencer: RTL

Packet-level sequencer above the UART receive controller. It consumes bytes from the receive path via the byte-ready flag and clear handshake, and frames them as header, length, payload and tail. It presents each complete payload to the core with a valid/ack handshake and reports malformed or stalled frames. It owns the receive controller's clear input and is the only block that may drive it.

---
 rtl/rx_packet_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/rx_packet_sequencer.sv
// Frames UART receive bytes as HEADER, LEN, payload, TAIL and hands complete payloads to the core.
// Latency: outputs are registered; oPktValid and the tail byte's oRxClear rise the cycle after the tail byte is accepted.
// Backpressure: while a payload waits for iPktAck no byte is accepted, so iRxFlag stays high upstream.
module rx_packet_sequencer #(
  parameter int         MAX_LEN = 4,
  parameter int         TIMEOUT = 50000,
  parameter logic [7:0] HEADER  = 8'hFE,
  parameter logic [7:0] TAIL    = 8'hEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iRxFlag,
  input  logic [7:0]             iRxData,
  output logic                   oRxClear,
  output logic                   oPktValid,
  input  logic                   iPktAck,
  output logic [2:0]             oPktLen,
  output logic [8*MAX_LEN-1:0]   oPktData,
  output logic                   oPktError,
  output logic                   oBusy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_DATA,
    ST_TAIL,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t        state;
  state_t        nextState;
  logic          drain;
  logic          accept;
  logic          lenOk;
  logic          timedOut;
  logic [2:0]    byteIdx;
  logic [TW-1:0] timer;

  always_comb begin
    accept    = iRxFlag && !drain &&
                (state inside {ST_HUNT, ST_LEN, ST_DATA, ST_TAIL});
    lenOk     = (iRxData != 8'd0) && (iRxData <= 8'(MAX_LEN));
    timedOut  = (timer == TW'(TIMEOUT - 1));
    nextState = state;
    case (state)
      ST_HUNT: if (accept && iRxData == HEADER) nextState = ST_LEN;
      ST_LEN: begin
        if (accept)        nextState = lenOk ? ST_DATA : ST_ERR;
        else if (timedOut) nextState = ST_ERR;
      end
      ST_DATA: begin
        if (accept) begin
          if (byteIdx == 3'(oPktLen - 3'd1)) nextState = ST_TAIL;
        end else if (timedOut) begin
          nextState = ST_ERR;
        end
      end
      ST_TAIL: begin
        if (accept)        nextState = (iRxData == TAIL) ? ST_DONE : ST_ERR;
        else if (timedOut) nextState = ST_ERR;
      end
      ST_DONE: if (iPktAck) nextState = ST_HUNT;
      ST_ERR:  nextState = ST_HUNT;
      default: nextState = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_HUNT;
    else        state <= nextState;
  end

  // Status outputs are driven from nextState so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain     <= 1'b0;
      oRxClear  <= 1'b0;
      oPktValid <= 1'b0;
      oPktError <= 1'b0;
      oBusy     <= 1'b0;
      timer     <= '0;
    end else begin
      drain     <= accept | (drain & iRxFlag);
      oRxClear  <= accept;
      oPktValid <= (nextState == ST_DONE);
      oPktError <= (nextState == ST_ERR);
      oBusy     <= (nextState != ST_HUNT);
      if (accept)
        timer <= '0;
      else if (state inside {ST_LEN, ST_DATA, ST_TAIL})
        timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oPktLen  <= 3'd0;
      oPktData <= '0;
      byteIdx  <= 3'd0;
    end else if (accept) begin
      if (state == ST_HUNT && iRxData == HEADER)
        oPktData <= '0;
      if (state == ST_LEN && lenOk) begin
        oPktLen <= iRxData[2:0];
        byteIdx <= 3'd0;
      end
      if (state == ST_DATA) begin
        for (int k = 0; k < MAX_LEN; k++)
          if (byteIdx == 3'(k)) oPktData[8*k +: 8] <= iRxData;
        byteIdx <= byteIdx + 3'd1;
      end
    end
  end

endmodule
